instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit.sv | 84 ++++++++
 tb/tb_instruction_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the async-read instruction ROM and
// registers the returned word into IF/ID, honouring reset > redirect > stall.
module instruction_fetch_unit #(
  parameter int unsigned          ADDR_W   = 7,
  parameter logic [ADDR_W-1:0]    PC_RESET = '0,
  parameter logic [31:0]          NOP_WORD = 32'h80000000,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              pc_wrap,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CntOne = CNT_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic              pc_wrap_q, pc_wrap_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    pc_wrap_d     = 1'b0;

    if (redirect_valid) begin
      // The word currently on imem_instr belongs to the wrong path; drop it.
      pc_d          = redirect_addr;
      if_id_instr_d = NOP_WORD;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_q + PcOne;
      if_id_instr_d = imem_instr;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      pc_wrap_d     = &pc_q;
      if (!(&fetch_count_q)) begin
        fetch_count_d = fetch_count_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      if_id_instr_q <= NOP_WORD;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      pc_wrap_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      pc_wrap_q     <= pc_wrap_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;
  assign pc_wrap     = pc_wrap_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed plan steps plus random traffic,
// all outputs checked each edge against a behavioural model of the stage.
module tb_instruction_fetch_unit;

  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned CMAX  = 65535;
  localparam logic [31:0] NOP   = 32'h80000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_instr;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [31:0]   if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic          if_id_valid;
  logic          pc_wrap;
  logic [15:0]   fetch_count;

  logic [31:0] rom [DEPTH];

  int n_pass = 0;
  int n_total = 0;

  // Model state
  int          m_pc, m_ipc, m_cnt;
  logic [31:0] m_instr;
  logic        m_valid, m_wrap;

  instruction_fetch_unit #(
    .ADDR_W  (AW),
    .PC_RESET('0),
    .NOP_WORD(NOP),
    .CNT_W   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .pc_wrap       (pc_wrap),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"},   32'(imem_addr),   32'(m_pc));
    check({tag, ".if_id_instr"}, if_id_instr,      m_instr);
    check({tag, ".if_id_pc"},    32'(if_id_pc),    32'(m_ipc));
    check({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(m_valid));
    check({tag, ".pc_wrap"},     32'(pc_wrap),     32'(m_wrap));
    check({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model by the stage's rules, compare.
  task automatic step(input logic rst, input logic stl, input logic rv,
                      input int ra, input bit chk, input string tag);
    reset          = rst;
    stall          = stl;
    redirect_valid = rv;
    redirect_addr  = AW'(ra);
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_ipc = 0; m_valid = 1'b0; m_wrap = 1'b0; m_cnt = 0;
    end else if (rv) begin
      m_ipc = m_pc; m_pc = ra; m_instr = NOP; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (stl) begin
      m_wrap = 1'b0;
    end else begin
      m_instr = rom[m_pc];
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_wrap  = (m_pc == DEPTH - 1);
      m_pc    = (m_pc + 1) % DEPTH;
      if (m_cnt < CMAX) m_cnt++;
    end
    #1;
    if (chk) check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = NOP;
    rom[0] = 32'h8C010001;
    rom[1] = 32'h8C020002;
    rom[2] = 32'h8C030003;
    rom[5] = 32'h00220820;
    m_pc = 0; m_instr = NOP; m_ipc = 0; m_valid = 1'b0; m_wrap = 1'b0; m_cnt = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1, "reset");
    check("reset.addr_lit", 32'(imem_addr), 32'd0);
    check("reset.instr_lit", if_id_instr, NOP);

    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "first");
    check("first.instr_lit", if_id_instr, 32'h8C010001);
    check("first.addr_lit", 32'(imem_addr), 32'd1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "second");
    check("second.cnt_lit", 32'(fetch_count), 32'd2);

    step(1'b0, 1'b1, 1'b0, 0, 1'b1, "stall1");
    step(1'b0, 1'b1, 1'b0, 0, 1'b1, "stall2");
    check("stall.instr_lit", if_id_instr, 32'h8C020002);
    check("stall.addr_lit", 32'(imem_addr), 32'd2);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "unstall");
    check("unstall.instr_lit", if_id_instr, 32'h8C030003);

    step(1'b0, 1'b0, 1'b1, 5, 1'b1, "redir5");
    check("redir5.valid_lit", 32'(if_id_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "after_redir5");
    check("after_redir5.instr_lit", if_id_instr, 32'h00220820);

    step(1'b0, 1'b1, 1'b1, 0, 1'b1, "stall_redir0");
    check("stall_redir0.addr_lit", 32'(imem_addr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "after_redir0");
    check("after_redir0.instr_lit", if_id_instr, 32'h8C010001);

    step(1'b0, 1'b0, 1'b1, 0, 1'b1, "redir_back2back_a");
    step(1'b0, 1'b0, 1'b1, 3, 1'b1, "redir_back2back_b");
    step(1'b0, 1'b0, 1'b1, 3, 1'b1, "redir_same_pc");
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "after_same_pc");

    step(1'b0, 1'b0, 1'b1, 127, 1'b1, "redir127");
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "wrap");
    check("wrap.pulse_lit", 32'(pc_wrap), 32'd1);
    check("wrap.ipc_lit", 32'(if_id_pc), 32'd127);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "wrap_clear");

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(4) == 0),
           ($urandom_range(7) == 0), int'($urandom_range(DEPTH - 1)), 1'b1, "rand");
    end

    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "pre_midreset");
    step(1'b1, 1'b1, 1'b1, 9, 1'b1, "midreset");
    check("midreset.addr_lit", 32'(imem_addr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "resume");
    check("resume.instr_lit", if_id_instr, 32'h8C010001);

    for (int i = 0; i < 65540; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, "sat_run");
    check_all("saturated");
    check("saturated.cnt_lit", 32'(fetch_count), 32'h0000FFFF);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, "saturated_hold");
    check("saturated_hold.cnt_lit", 32'(fetch_count), 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
